// File: rtl/dbm_to_power.sv
// dbm_to_power: converts signed Q16.16 dB (10*log10 P) to linear power floor(10^(dB/10)).
// Latency: 4 clocks from valid_in sampled to valid_out; one sample per clock.
// Backpressure: none; a valid shift register runs alongside the data pipeline.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   valid_in, dbm_in      input strobe and signed Q16.16 dB value
//   valid_out, power_out  output strobe and unsigned 32-bit linear power (held between strobes)
//   sat_out, zero_out     result clamped to 0xFFFFFFFF / result underflowed to 0
module dbm_to_power #(
  parameter int FRAC_BITS = 16,
  parameter int LUT_BITS  = 8,
  parameter int K_LOG2    = 21771
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] dbm_in,
  output logic        valid_out,
  output logic [31:0] power_out,
  output logic        sat_out,
  output logic        zero_out
);

  // Only the integer exponent and the top LUT_BITS of the log2 fraction are
  // ever used, so the low fraction bits are dropped at the first register.
  localparam int DROP = FRAC_BITS - LUT_BITS;
  localparam int YW   = 32 - DROP;
  localparam int LUT_N = 1 << LUT_BITS;

  // Integer square root by bit-by-bit trial; operands are < 2^128.
  function automatic logic [127:0] isqrt(input logic [127:0] a);
    logic [127:0] r;
    logic [127:0] t;
    r = '0;
    for (int b = 63; b >= 0; b--) begin
      t = r | (128'd1 << b);
      if (t * t <= a) r = t;
    end
    return r;
  endfunction

  // Mantissa ROM entry round(2^(i/2^LUT_BITS) * 2^16), built at elaboration.
  // 2^(2^k/2^LUT_BITS) comes from repeated square roots of 2 in Q60, and the
  // entry is the product of the factors for the set bits of i. The Q60
  // truncation error is far below the final rounding step.
  function automatic logic [16:0] lut_val(input logic [LUT_BITS-1:0] i);
    logic [127:0] root;
    logic [127:0] acc;
    root = 128'd2 << 60;
    acc  = 128'd1 << 60;
    for (int k = LUT_BITS - 1; k >= 0; k--) begin
      root = isqrt(root << 60);
      if (i[k]) acc = (acc * root) >> 60;
    end
    acc = (acc + (128'd1 << 43)) >> 44;
    return acc[16:0];
  endfunction

  logic [16:0] lut_rom [LUT_N];
  for (genvar g = 0; g < LUT_N; g++) begin : g_lut
    localparam logic [16:0] M_G = lut_val(LUT_BITS'(g));
    assign lut_rom[g] = M_G;
  end

  // S1: dB * log2(10)/10. Sign-extending to 48 bits keeps 0x80000000 exact.
  logic signed [47:0] prod;
  assign prod = $signed({{16{dbm_in[31]}}, dbm_in}) * $signed({32'd0, 16'(K_LOG2)});

  logic [3:0]         vld_q;
  logic [YW-1:0]      ylog_q;   // floor(log2 value) in Q16.LUT_BITS
  logic signed [15:0] n2_q;     // integer exponent
  logic [16:0]        m2_q;     // mantissa 2^f in Q1.16
  logic [31:0]        res3_q;
  logic               sat3_q;
  logic               zero3_q;

  // S3 classification and shift
  logic [31:0] res3;
  logic        sat3;
  logic        zero3;
  logic [5:0]  sh_r;

  // 16-n lies in 1..33 whenever the right-shift branch is taken.
  assign sh_r = 6'd16 - n2_q[5:0];

  always_comb begin
    res3 = '0;
    sat3 = 1'b0;
    if (n2_q >= 16'sd32) begin
      res3 = '1;
      sat3 = 1'b1;
    end else if (n2_q <= -16'sd18) begin
      res3 = '0;
    end else if (n2_q >= 16'sd16) begin
      // n in 16..31, so n-16 is just the low nibble
      res3 = 32'(m2_q) << n2_q[3:0];
    end else begin
      res3 = 32'(m2_q) >> sh_r;
    end
    zero3 = !sat3 && (res3 == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      ylog_q    <= '0;
      n2_q      <= '0;
      m2_q      <= '0;
      res3_q    <= '0;
      sat3_q    <= 1'b0;
      zero3_q   <= 1'b0;
      valid_out <= 1'b0;
      power_out <= '0;
      sat_out   <= 1'b0;
      zero_out  <= 1'b0;
    end else begin
      vld_q   <= {vld_q[2:0], valid_in};
      ylog_q  <= YW'(prod >>> (FRAC_BITS + DROP));
      n2_q    <= $signed(ylog_q[YW-1:LUT_BITS]);
      m2_q    <= lut_rom[ylog_q[LUT_BITS-1:0]];
      res3_q  <= res3;
      sat3_q  <= sat3;
      zero3_q <= zero3;
      // Flags are strobes; power_out keeps the last delivered result.
      valid_out <= vld_q[2];
      sat_out   <= vld_q[2] & sat3_q;
      zero_out  <= vld_q[2] & zero3_q;
      if (vld_q[2]) power_out <= res3_q;
    end
  end

endmodule

// File: tb/tb_dbm_to_power.sv
module tb_dbm_to_power;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] dbm_in = '0;
  logic        valid_out;
  logic [31:0] power_out;
  logic        sat_out;
  logic        zero_out;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] pw;
    logic        sat;
    logic        zero;
    int          cyc;
    bit          acc;
  } exp_t;

  exp_t   sb[$];
  longint lut_m [256];

  localparam logic [31:0] BD     [6] = '{32'h0000_0000, 32'h001E_0000, 32'h0060_0000,
                                         32'h0064_0000, 32'hFFC4_0000, 32'h8000_0000};
  localparam logic [31:0] BD_PW  [6] = '{32'd1, 32'd999, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0};
  localparam logic        BD_SAT [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic        BD_ZR  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  dbm_to_power dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .dbm_in    (dbm_in),
    .valid_out (valid_out),
    .power_out (power_out),
    .sat_out   (sat_out),
    .zero_out  (zero_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] d);
    exp_t   e;
    longint y;
    longint n;
    longint r;
    int     idx;
    y   = (longint'($signed(d)) * 64'sd21771) >>> 16;
    n   = y >>> 16;
    idx = int'(y[15:8]);
    e.cyc = 0;
    e.acc = 1'b0;
    e.sat = 1'b0;
    r = 0;
    if (n >= 32) begin
      r = 64'hFFFF_FFFF;
      e.sat = 1'b1;
    end else if (n <= -18) begin
      r = 0;
    end else if (n >= 16) begin
      r = lut_m[idx] << (n - 16);
    end else begin
      r = lut_m[idx] >> (16 - n);
    end
    e.pw   = r[31:0];
    e.zero = !e.sat && (e.pw == 32'd0);
    return e;
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== 1'b0 || power_out !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_hold: valid_out=%b power_out=%h, want 0/0", valid_out, power_out);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== 1'b0 || power_out !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_idle: valid_out=%b power_out=%h, want 0/0", valid_out, power_out);
      end
    end
  endtask

  task automatic test_boundary();
    exp_t e;
    for (int t = 0; t < 6; t++) begin
      for (int c = 0; c < 7; c++) begin
        @(posedge clk);
        #1;
        valid_in = (c == 0);
        dbm_in   = BD[t];
        if (c == 0) begin
          e = model(BD[t]);
          if (t != 2) e.pw = BD_PW[t];
          e.sat  = BD_SAT[t];
          e.zero = BD_ZR[t];
          e.cyc  = cyc;
          sb.push_back(e);
        end
        @(negedge clk);
        if (valid_out) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL boundary: unexpected valid_out power_out=%h", power_out);
          end else begin
            e = sb.pop_front();
            if (power_out !== e.pw || sat_out !== e.sat || zero_out !== e.zero || cyc - e.cyc != 4) begin
              n_bad++;
              $display("FAIL boundary[%0d]: got power=%h sat=%b zero=%b lat=%0d, want power=%h sat=%b zero=%b lat=4",
                       t, power_out, sat_out, zero_out, cyc - e.cyc, e.pw, e.sat, e.zero);
            end
          end
        end else if (sb.size() != 0 && cyc - sb[0].cyc >= 4) begin
          n_cmp++;
          n_bad++;
          e = sb.pop_front();
          $display("FAIL boundary[%0d]: no valid_out, want power=%h", t, e.pw);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] sd[$];
    bit          sv[$];
    longint      diff;
    int          nst;
    for (int k = 0; k < 5000; k++) begin
      sd.push_back(32'(-64'sd655360 + (longint'(k) * 64'sd6881280) / 64'sd4999));
      sv.push_back(1'b1);
    end
    sd.push_back(32'($rtoi(90.3067 * 65536.0)));
    sv.push_back(1'b1);
    for (int k = 0; k < 40; k++) begin
      sd.push_back(32'(int'($urandom_range(0, 2 * 128 * 65536)) - 128 * 65536));
      sv.push_back(k % 2 == 0);
    end
    nst = sd.size();
    for (int k = 0; k < nst + 8; k++) begin
      @(posedge clk);
      #1;
      valid_in = (k < nst) ? sv[k] : 1'b0;
      dbm_in   = (k < nst) ? sd[k] : 32'd0;
      if (valid_in) begin
        e = model(dbm_in);
        e.cyc = cyc;
        e.acc = (k == 5000);
        sb.push_back(e);
      end
      @(negedge clk);
      if (valid_out) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL stream: unexpected valid_out power_out=%h", power_out);
        end else begin
          e = sb.pop_front();
          if (power_out !== e.pw || sat_out !== e.sat || zero_out !== e.zero || cyc - e.cyc != 4) begin
            n_bad++;
            $display("FAIL stream: got power=%h sat=%b zero=%b lat=%0d, want power=%h sat=%b zero=%b lat=4",
                     power_out, sat_out, zero_out, cyc - e.cyc, e.pw, e.sat, e.zero);
          end
          if (e.acc) begin
            n_cmp++;
            diff = longint'(power_out) - 64'sd1073217600;
            if (diff < 0) diff = -diff;
            if (diff * 1000 > 64'sd3 * 64'sd1073217600) begin
              n_bad++;
              $display("FAIL accuracy_90.3067dB: power_out=%0d, want within 0.3%% of 1073217600", power_out);
            end
          end
        end
      end else if (sb.size() != 0 && cyc - sb[0].cyc >= 4) begin
        n_cmp++;
        n_bad++;
        e = sb.pop_front();
        $display("FAIL stream: no valid_out, want power=%h", e.pw);
      end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    // One delivered sample so power_out is nonzero before the reset hits.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      valid_in = (c == 0);
      dbm_in   = 32'h001E_0000;
      if (c == 0) begin
        e = model(dbm_in);
        e.cyc = cyc;
        sb.push_back(e);
      end
      @(negedge clk);
      if (valid_out) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL midreset_pre: unexpected valid_out power_out=%h", power_out);
        end else begin
          e = sb.pop_front();
          if (power_out !== e.pw || sat_out !== e.sat || zero_out !== e.zero || cyc - e.cyc != 4) begin
            n_bad++;
            $display("FAIL midreset_pre: got power=%h lat=%0d, want power=%h lat=4",
                     power_out, cyc - e.cyc, e.pw);
          end
        end
      end else if (sb.size() != 0 && cyc - sb[0].cyc >= 4) begin
        n_cmp++;
        n_bad++;
        e = sb.pop_front();
        $display("FAIL midreset_pre: no valid_out, want power=%h", e.pw);
      end
    end
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      valid_in = 1'b1;
      dbm_in   = 32'(20 + s) << 16;
    end
    @(posedge clk);
    #3;
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || power_out !== 32'd0 || sat_out !== 1'b0 || zero_out !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_clear: valid=%b power=%h sat=%b zero=%b, want all 0",
               valid_out, power_out, sat_out, zero_out);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL midreset_flush: valid_out=%b power_out=%h after release, want 0", valid_out, power_out);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      lut_m[i] = longint'($rtoi($pow(2.0, i / 256.0) * 65536.0 + 0.5));
    test_reset();
    test_boundary();
    test_back_to_back();
    test_reset_midstream();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d outputs never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
